// File: rtl/rom_burst_reader_pkg.sv
`default_nettype none
// ============================================================================
// rom_burst_reader_pkg : shared widths, FSM state and FIFO entry types
// Revision: 1.0
// ============================================================================
package rom_burst_reader_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 4;
  localparam int DEF_LEN_W  = DEF_ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic                  last;
    logic [DEF_DATA_W-1:0] data;
  } rom_entry_t;

endpackage
`default_nettype wire

// File: rtl/rom_burst_reader_if.sv
`default_nettype none
// ============================================================================
// rom_burst_reader_if : request, ROM and output-stream signals of the reader
// Revision: 1.0
// ============================================================================
interface rom_burst_reader_if
  import rom_burst_reader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
) ();

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;

  modport slave (
    input  req_valid, req_addr, req_len, rom_data, out_ready,
    output req_ready, rom_en, rom_addr, out_valid, out_data, out_last, busy
  );

  modport master (
    output req_valid, req_addr, req_len, rom_data, out_ready,
    input  req_ready, rom_en, rom_addr, out_valid, out_data, out_last, busy
  );

endinterface
`default_nettype wire

// File: rtl/rom_burst_fifo.sv
`default_nettype none
// ============================================================================
// rom_burst_fifo : 2-entry FIFO of {last, data} entries, push/pop same cycle ok
// Revision: 1.0
// ============================================================================
module rom_burst_fifo
  import rom_burst_reader_pkg::*;
(
  input  wire        clk,
  input  wire        rst,
  input  wire        i_push,
  input  wire        i_pop,
  input  rom_entry_t i_data,
  output rom_entry_t o_head,
  output logic [1:0] o_count,
  output logic       o_empty,
  output logic       o_full
);

  rom_entry_t r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) r_wr_ptr <= ~r_wr_ptr;
      if (i_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == 2'd0);
  assign o_full  = (r_count == 2'd2);

endmodule
`default_nettype wire

// File: rtl/rom_burst_reader.sv
`default_nettype none
// ============================================================================
// rom_burst_reader : burst read initiator for a 1-cycle-latency synchronous ROM
// Optional XOR checksum beat: define ROM_BURST_READER_CHECKSUM_EN
// Revision: 1.0
// ============================================================================
module rom_burst_reader
  import rom_burst_reader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input wire                 clk,
  input wire                 rst,
  rom_burst_reader_if.slave  bus
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_remain;
  logic              r_inflight;
  logic              r_inflight_last;
  logic              w_accept;
  logic              w_req_ready;
  logic              w_issue;
  logic              w_credit_ok;
  logic              w_pop;
  logic              w_push;
  logic              w_pend_any;
  logic              w_drain_done;
  rom_entry_t        w_push_entry;
  rom_entry_t        w_head;
  logic [1:0]        w_count;
  logic              w_empty;
  logic              w_full;

  assign w_accept = bus.req_valid && w_req_ready;
  assign w_pop    = !w_empty && bus.out_ready;

  // A slot must be free once the in-flight word lands; a same-cycle pop frees one.
  assign w_credit_ok = r_inflight ? (w_empty || (w_count == 2'd1 && w_pop))
                                  : (!w_full || w_pop);

  assign w_drain_done = !r_inflight && !w_pend_any &&
                        (w_empty || (w_count == 2'd1 && w_pop));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = 1'b0;
    w_issue     = 1'b0;
    case (r_state)
      IDLE: begin
        w_req_ready = !rst;
        if (w_accept && bus.req_len != '0) w_state_nxt = ISSUE;
      end
      ISSUE: begin
        w_issue = w_credit_ok;
        if (w_credit_ok && r_remain == LEN_W'(1)) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (w_drain_done) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr          <= '0;
      r_remain        <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue && (r_remain == LEN_W'(1));
      if (w_accept) begin
        r_addr   <= bus.req_addr;
        r_remain <= bus.req_len;
      end else if (w_issue) begin
        r_addr   <= r_addr + ADDR_W'(1);
        r_remain <= r_remain - LEN_W'(1);
      end
    end
  end

`ifdef ROM_BURST_READER_CHECKSUM_EN
  logic [DATA_W-1:0] r_csum;
  logic              r_csum_pend;
  logic              w_csum_push;

  assign w_csum_push = r_csum_pend && (!w_full || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_csum      <= '0;
      r_csum_pend <= 1'b0;
    end else begin
      if (w_accept)        r_csum <= '0;
      else if (r_inflight) r_csum <= r_csum ^ bus.rom_data;
      r_csum_pend <= (r_csum_pend && !w_csum_push) || (r_inflight && r_inflight_last);
    end
  end

  // The checksum beat never collides with a data push: it is armed after the last return.
  assign w_push       = r_inflight || w_csum_push;
  assign w_push_entry = r_inflight ? '{last: 1'b0, data: bus.rom_data}
                                   : '{last: 1'b1, data: r_csum};
  assign w_pend_any   = r_csum_pend;
`else
  assign w_push       = r_inflight;
  assign w_push_entry = '{last: r_inflight_last, data: bus.rom_data};
  assign w_pend_any   = 1'b0;
`endif

  rom_burst_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_push_entry),
    .o_head  (w_head),
    .o_count (w_count),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  assign bus.req_ready = w_req_ready;
  assign bus.rom_en    = w_issue;
  assign bus.rom_addr  = r_addr;
  assign bus.out_valid = !w_empty;
  assign bus.out_data  = w_empty ? {DATA_W{1'b0}} : w_head.data;
  assign bus.out_last  = !w_empty && w_head.last;
  assign bus.busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_rom_burst_reader.sv
`default_nettype none
// ============================================================================
// tb_rom_burst_reader : table-driven and random bursts against a beat-list model
// Revision: 1.0
// ============================================================================
module tb_rom_burst_reader;
  import rom_burst_reader_pkg::*;

`ifdef ROM_BURST_READER_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rom_burst_reader_if bus ();
  rom_burst_reader dut (.clk(clk), .rst(rst), .bus(bus.slave));

  logic [3:0] rom [32];
  logic [3:0] rom_q = 4'd0;
  always @(posedge clk) if (bus.rom_en) rom_q <= rom[bus.rom_addr];
  assign bus.rom_data = rom_q;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;
  int rdy_mode = 0;

  // monitor state
  int got_q[$];
  int addr_q[$];
  int acc_cyc, first_en, first_valid, last_xfer, busy_fall, n_iss, n_xfer;
  bit acc_seen, busy_seen, stall_prev, prev_busy;
  int prev_data, prev_last;

  task automatic chk(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic clear_mon();
    got_q.delete(); addr_q.delete();
    acc_cyc = -1; first_en = -1; first_valid = -1; last_xfer = -1; busy_fall = -1;
    n_iss = 0; n_xfer = 0; acc_seen = 0; busy_seen = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 0; prev_busy = 0;
    end else begin
      if (bus.req_valid && bus.req_ready) begin acc_cyc = cyc; acc_seen = 1; end
      if (bus.busy) busy_seen = 1;
      if (prev_busy && !bus.busy) busy_fall = cyc;
      prev_busy = bus.busy;
      if (bus.rom_en) begin
        chk("rom_en_credit", int'((n_iss - n_xfer - ((bus.out_valid && bus.out_ready) ? 1 : 0)) < 2), 1);
        chk("rom_en_while_idle", int'(bus.busy && !bus.req_ready), 1);
        if (first_en < 0) first_en = cyc;
        addr_q.push_back(int'(bus.rom_addr));
        n_iss++;
      end
      if (stall_prev) begin
        chk("stall_valid", int'(bus.out_valid), 1);
        chk("stall_data", int'(bus.out_data), prev_data);
        chk("stall_last", int'(bus.out_last), prev_last);
      end
      if (bus.out_valid && first_valid < 0) first_valid = cyc;
      if (bus.out_valid && bus.out_ready) begin
        got_q.push_back(int'(bus.out_last) * 16 + int'(bus.out_data));
        last_xfer = cyc;
        n_xfer++;
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      prev_data  = int'(bus.out_data);
      prev_last  = int'(bus.out_last);
    end
  end

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        2:       bus.out_ready = ((cyc % 3) == 0);
        default: bus.out_ready = 1'b1;
      endcase
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, int'(bus.out_valid), 0);
    chk({tag, "_out_data"},  int'(bus.out_data), 0);
    chk({tag, "_out_last"},  int'(bus.out_last), 0);
    chk({tag, "_rom_en"},    int'(bus.rom_en), 0);
    chk({tag, "_rom_addr"},  int'(bus.rom_addr), 0);
    chk({tag, "_busy"},      int'(bus.busy), 0);
    chk({tag, "_req_ready"}, int'(bus.req_ready), 0);
  endtask

  task automatic run_burst(input int a, input int l, input int mode, input bit lat);
    int exp_q[$];
    int exp_addr[$];
    int x, d, t, nb;
    exp_q.delete(); exp_addr.delete();
    x = 0;
    for (int i = 0; i < l; i++) begin
      d = int'(rom[(a + i) % 32]);
      x = x ^ d;
      exp_addr.push_back((a + i) % 32);
      exp_q.push_back(((i == l - 1 && !CS) ? 16 : 0) + d);
    end
    if (CS && l > 0) exp_q.push_back(16 + x);
    nb = exp_q.size();

    rdy_mode = mode;
    clear_mon();
    bus.req_addr  = 5'(a);
    bus.req_len   = 6'(l);
    bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
    t = 0;
    while (got_q.size() < nb && t < 2000) begin step(); t++; end
    chk("burst_timeout", int'(t < 2000), 1);
    repeat (6) step();
    rdy_mode = 0;

    chk("req_accepted", int'(acc_seen), 1);
    chk("beat_count", got_q.size(), nb);
    for (int i = 0; i < nb && i < got_q.size(); i++) chk("beat_value", got_q[i], exp_q[i]);
    chk("issue_count", addr_q.size(), l);
    for (int i = 0; i < l && i < addr_q.size(); i++) chk("rom_addr_seq", addr_q[i], exp_addr[i]);
    chk("busy_after", int'(bus.busy), 0);
    chk("ready_after", int'(bus.req_ready), 1);
    if (l == 0) begin
      chk("len0_busy_seen", int'(busy_seen), 0);
    end else begin
      chk("busy_fall", busy_fall, last_xfer + 1);
      if (lat) begin
        chk("first_rom_en", first_en, acc_cyc + 1);
        chk("first_valid", first_valid, acc_cyc + 3);
        chk("last_xfer", last_xfer, acc_cyc + nb + 2);
      end
    end
  endtask

  typedef struct {
    int a;
    int l;
    int mode;
    bit lat;
  } vec_t;
  vec_t tbl [8];

  initial begin
    int t;
    tbl[0] = '{1, 5, 0, 1'b1};
    tbl[1] = '{30, 4, 0, 1'b1};
    tbl[2] = '{0, 8, 2, 1'b0};
    tbl[3] = '{5, 0, 0, 1'b0};
    tbl[4] = '{0, 32, 0, 1'b1};
    tbl[5] = '{31, 1, 0, 1'b1};
    tbl[6] = '{2, 3, 0, 1'b1};
    tbl[7] = '{17, 20, 1, 1'b0};
    for (int i = 0; i < 32; i++) rom[i] = 4'(i);
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    clear_mon();

    #1 check_reset_outputs("por");
    repeat (3) step();
    rst = 1'b0;
    #1;
    chk("por_req_ready", int'(bus.req_ready), 1);
    chk("por_busy", int'(bus.busy), 0);
    step();

    foreach (tbl[i]) run_burst(tbl[i].a, tbl[i].l, tbl[i].mode, tbl[i].lat);

    // mid-burst reset: abandon the burst and confirm nothing trickles out after
    clear_mon();
    bus.req_addr = 5'd0; bus.req_len = 6'd16; bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
    t = 0;
    while (got_q.size() < 3 && t < 200) begin step(); t++; end
    chk("midrst_wait", int'(t < 200), 1);
    rst = 1'b1;
    #1 check_reset_outputs("midrst");
    step(); step();
    rst = 1'b0;
    #1;
    chk("midrst_req_ready", int'(bus.req_ready), 1);
    chk("midrst_busy", int'(bus.busy), 0);
    clear_mon();
    repeat (6) step();
    chk("midrst_no_beats", got_q.size(), 0);
    chk("midrst_no_issue", n_iss, 0);
    run_burst(3, 2, 0, 1'b1);

    for (int i = 0; i < 32; i++) rom[i] = 4'($urandom_range(0, 15));
    for (int i = 0; i < 16; i++)
      run_burst($urandom_range(0, 31), $urandom_range(0, 32), $urandom_range(0, 2), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
